// File: rtl/systolic_2x2_feeder_pkg.sv
// Package: systolic_pkg
// Shared types and constants for the systolic_2x2 operand feeder.
//   state_e     : feeder FSM states
//   NUM_WAVES   : waves per sequence, including the trailing flush wave
//   DATA_W_DEF  : default element width
//   W_SKEW0..W_FLUSH : wave index encodings
//   cnt_width() : width of the shared gap/drain counter

package systolic_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned NUM_WAVES  = 4;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StGap,
      StDrain,
      StDone
   } state_e;

   localparam logic [1:0] W_SKEW0 = 2'd0;  // (a12, 0,   b21, 0  )
   localparam logic [1:0] W_MAIN  = 2'd1;  // (a11, a22, b11, b22)
   localparam logic [1:0] W_SKEW1 = 2'd2;  // (0,   a21, 0,   b12)
   localparam logic [1:0] W_FLUSH = 2'(NUM_WAVES - 1);  // all zero

   // Wide enough to hold the larger of the two wait lengths.
   function automatic int unsigned cnt_width(input int unsigned gap, input int unsigned drain);
      int unsigned m;
      m = (gap > drain) ? gap : drain;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/systolic_2x2_feeder_if.sv
// Interface: systolic_2x2_feeder_if
// Bundles the feeder's request/operand inputs and its load-side outputs.
//   master : requester (drives start and matrix elements, observes outputs)
//   slave  : the feeder itself
// Signals:
//   start, ready, busy               : request handshake
//   a11..a22, b11..b22               : operand matrices, sampled on accepted start
//   load_in, row_in_row0/1, col_in_col0/1 : wave strobe and buses to systolic_2x2
//   feed_done                        : one-cycle pulse, array results valid

interface systolic_2x2_feeder_if
   import systolic_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
);

   logic              start;
   logic              ready;
   logic              busy;
   logic [DATA_W-1:0] a11, a12, a21, a22;
   logic [DATA_W-1:0] b11, b12, b21, b22;
   logic              load_in;
   logic [DATA_W-1:0] row_in_row0, row_in_row1;
   logic [DATA_W-1:0] col_in_col0, col_in_col1;
   logic              feed_done;

   modport master (
      output start, a11, a12, a21, a22, b11, b12, b21, b22,
      input  ready, busy, load_in, row_in_row0, row_in_row1, col_in_col0, col_in_col1,
             feed_done
   );

   modport slave (
      input  start, a11, a12, a21, a22, b11, b12, b21, b22,
      output ready, busy, load_in, row_in_row0, row_in_row1, col_in_col0, col_in_col1,
             feed_done
   );

endinterface

// File: rtl/systolic_2x2_feeder_wave_sel.sv
// Module: systolic_wave_sel
// Combinational wave-index to 4-bus selector for the 2x2 skewed load pattern.
// Ports:
//   wave               in  2-bit wave index
//   a11..a22, b11..b22 in  matrix elements
//   row0, row1         out row operands
//   col0, col1         out column operands

module systolic_wave_sel
   import systolic_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic [1:0]        wave,
   input  logic [DATA_W-1:0] a11,
   input  logic [DATA_W-1:0] a12,
   input  logic [DATA_W-1:0] a21,
   input  logic [DATA_W-1:0] a22,
   input  logic [DATA_W-1:0] b11,
   input  logic [DATA_W-1:0] b12,
   input  logic [DATA_W-1:0] b21,
   input  logic [DATA_W-1:0] b22,
   output logic [DATA_W-1:0] row0,
   output logic [DATA_W-1:0] row1,
   output logic [DATA_W-1:0] col0,
   output logic [DATA_W-1:0] col1
);

   always_comb begin
      row0 = '0;
      row1 = '0;
      col0 = '0;
      col1 = '0;
      unique case (wave)
         W_SKEW0: begin
            row0 = a12;
            col0 = b21;
         end
         W_MAIN: begin
            row0 = a11;
            row1 = a22;
            col0 = b11;
            col1 = b22;
         end
         W_SKEW1: begin
            row1 = a21;
            col1 = b12;
         end
         W_FLUSH: begin
         end
      endcase
   end

endmodule

// File: rtl/systolic_2x2_feeder.sv
// Module: systolic_2x2_feeder
// Latches two 2x2 matrices on an accepted start, then plays the four skewed waves into
// systolic_2x2 (one load_in strobe per wave, buses held through each gap), waits out the
// array drain and pulses feed_done.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-low reset
//   bus  slave modport of systolic_2x2_feeder_if (handshake, operands, load-side outputs)
// Every output is a flop. The output flops are loaded from the next-state values so the
// registered outputs line up with the FSM state they describe.

module systolic_2x2_feeder
   import systolic_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned WAVE_GAP  = 15,
   parameter int unsigned DRAIN_CYC = 100
) (
   input logic                  clk,
   input logic                  rst,
   systolic_2x2_feeder_if.slave bus
);

   localparam int unsigned     CntW      = cnt_width(WAVE_GAP, DRAIN_CYC);
   localparam logic [CntW-1:0] GapInit   = CntW'(WAVE_GAP - 1);
   localparam logic [CntW-1:0] DrainInit = CntW'(DRAIN_CYC - 1);

   state_e            state_q, state_d;
   logic [1:0]        wave_q, wave_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] mat_q [8];  // a11, a12, a21, a22, b11, b12, b21, b22
   logic [DATA_W-1:0] mat_d [8];

   logic              ready_q, busy_q, load_in_q, feed_done_q;
   logic [DATA_W-1:0] row0_q, row1_q, col0_q, col1_q;

   logic              accept;
   logic              drive_d;
   logic [DATA_W-1:0] sel_row0, sel_row1, sel_col0, sel_col1;

   assign accept = bus.start && ready_q;

   // Next-state: FSM, wave index and the shared gap/drain down-counter.
   always_comb begin
      state_d = state_q;
      wave_d  = wave_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StLoad;
               wave_d  = W_SKEW0;
            end
         end
         StLoad: begin
            state_d = StGap;
            cnt_d   = GapInit;
         end
         StGap: begin
            if (cnt_q == '0) begin
               if (wave_q == W_FLUSH) begin
                  state_d = StDrain;
                  cnt_d   = DrainInit;
               end else begin
                  state_d = StLoad;
                  wave_d  = wave_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StDrain: begin
            if (cnt_q == '0) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Operands are captured only on acceptance; later input changes are ignored.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         mat_d[i] = mat_q[i];
      end
      if (accept) begin
         mat_d[0] = bus.a11;
         mat_d[1] = bus.a12;
         mat_d[2] = bus.a21;
         mat_d[3] = bus.a22;
         mat_d[4] = bus.b11;
         mat_d[5] = bus.b12;
         mat_d[6] = bus.b21;
         mat_d[7] = bus.b22;
      end
   end

   // Selector runs on next-state values so its result can be registered in step.
   systolic_wave_sel #(
      .DATA_W (DATA_W)
   ) u_wave_sel (
      .wave (wave_d),
      .a11  (mat_d[0]),
      .a12  (mat_d[1]),
      .a21  (mat_d[2]),
      .a22  (mat_d[3]),
      .b11  (mat_d[4]),
      .b12  (mat_d[5]),
      .b21  (mat_d[6]),
      .b22  (mat_d[7]),
      .row0 (sel_row0),
      .row1 (sel_row1),
      .col0 (sel_col0),
      .col1 (sel_col1)
   );

   // Buses carry wave data from LOAD through DRAIN; zero in IDLE and DONE.
   assign drive_d = (state_d == StLoad) || (state_d == StGap) || (state_d == StDrain);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         wave_q      <= W_SKEW0;
         cnt_q       <= '0;
         for (int i = 0; i < 8; i++) begin
            mat_q[i] <= '0;
         end
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         load_in_q   <= 1'b0;
         feed_done_q <= 1'b0;
         row0_q      <= '0;
         row1_q      <= '0;
         col0_q      <= '0;
         col1_q      <= '0;
      end else begin
         state_q     <= state_d;
         wave_q      <= wave_d;
         cnt_q       <= cnt_d;
         for (int i = 0; i < 8; i++) begin
            mat_q[i] <= mat_d[i];
         end
         ready_q     <= (state_d == StIdle);
         busy_q      <= (state_d != StIdle);
         load_in_q   <= (state_d == StLoad);
         feed_done_q <= (state_d == StDone);
         row0_q      <= drive_d ? sel_row0 : '0;
         row1_q      <= drive_d ? sel_row1 : '0;
         col0_q      <= drive_d ? sel_col0 : '0;
         col1_q      <= drive_d ? sel_col1 : '0;
      end
   end

   assign bus.ready       = ready_q;
   assign bus.busy        = busy_q;
   assign bus.load_in     = load_in_q;
   assign bus.feed_done   = feed_done_q;
   assign bus.row_in_row0 = row0_q;
   assign bus.row_in_row1 = row1_q;
   assign bus.col_in_col0 = col0_q;
   assign bus.col_in_col1 = col1_q;

endmodule

// File: tb/tb_systolic_2x2_feeder.sv
// Testbench: tb_systolic_2x2_feeder
// Directed bench for systolic_2x2_feeder. Two instances: default timing (gap 15, drain 100)
// and short timing (gap 1, drain 1). Expected per-cycle outputs come from the wave table
// and the timing formulas: wave w strobes at t = 1 + w*(gap+1), feed_done at
// t = 1 + 4*(gap+1) + drain, where t counts cycles after the accepting edge.

module tb_systolic_2x2_feeder;

   logic        clk;
   logic        rst_n;
   logic        start_s, start_f;
   logic [31:0] a11, a12, a21, a22, b11, b12, b21, b22;
   logic        sel_fast;

   logic [31:0] ew [4][4];  // expected (row0, row1, col0, col1) per wave

   int n_chk;
   int n_fail;

   systolic_2x2_feeder_if #(.DATA_W(32)) s_if ();
   systolic_2x2_feeder_if #(.DATA_W(32)) f_if ();

   assign s_if.start = start_s;
   assign s_if.a11   = a11;
   assign s_if.a12   = a12;
   assign s_if.a21   = a21;
   assign s_if.a22   = a22;
   assign s_if.b11   = b11;
   assign s_if.b12   = b12;
   assign s_if.b21   = b21;
   assign s_if.b22   = b22;

   assign f_if.start = start_f;
   assign f_if.a11   = a11;
   assign f_if.a12   = a12;
   assign f_if.a21   = a21;
   assign f_if.a22   = a22;
   assign f_if.b11   = b11;
   assign f_if.b12   = b12;
   assign f_if.b21   = b21;
   assign f_if.b22   = b22;

   systolic_2x2_feeder #(
      .DATA_W    (32),
      .WAVE_GAP  (15),
      .DRAIN_CYC (100)
   ) u_dut (
      .clk (clk),
      .rst (rst_n),
      .bus (s_if.slave)
   );

   systolic_2x2_feeder #(
      .DATA_W    (32),
      .WAVE_GAP  (1),
      .DRAIN_CYC (1)
   ) u_dut_fast (
      .clk (clk),
      .rst (rst_n),
      .bus (f_if.slave)
   );

   logic        o_ld, o_fd, o_rdy, o_bsy;
   logic [31:0] o_r0, o_r1, o_c0, o_c1;

   assign o_ld  = sel_fast ? f_if.load_in     : s_if.load_in;
   assign o_fd  = sel_fast ? f_if.feed_done   : s_if.feed_done;
   assign o_rdy = sel_fast ? f_if.ready       : s_if.ready;
   assign o_bsy = sel_fast ? f_if.busy        : s_if.busy;
   assign o_r0  = sel_fast ? f_if.row_in_row0 : s_if.row_in_row0;
   assign o_r1  = sel_fast ? f_if.row_in_row1 : s_if.row_in_row1;
   assign o_c0  = sel_fast ? f_if.col_in_col0 : s_if.col_in_col0;
   assign o_c1  = sel_fast ? f_if.col_in_col1 : s_if.col_in_col1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int t, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s t=%0d: observed %h expected %h", tag, t, obs, exp);
      end
   endtask

   // Drive operands and derive the expected wave table from them.
   task automatic set_ops(input logic [31:0] x11, x12, x21, x22, y11, y12, y21, y22);
      a11 = x11; a12 = x12; a21 = x21; a22 = x22;
      b11 = y11; b12 = y12; b21 = y21; b22 = y22;
      ew[0][0] = x12; ew[0][1] = 32'd0; ew[0][2] = y21; ew[0][3] = 32'd0;
      ew[1][0] = x11; ew[1][1] = x22;   ew[1][2] = y11; ew[1][3] = y22;
      ew[2][0] = 32'd0; ew[2][1] = x21; ew[2][2] = 32'd0; ew[2][3] = y12;
      for (int i = 0; i < 4; i++) ew[3][i] = 32'd0;
   endtask

   task automatic check_idle_out(input string tag, input int t);
      chk({tag, ".load_in"},   t, 32'(o_ld),  32'd0);
      chk({tag, ".feed_done"}, t, 32'(o_fd),  32'd0);
      chk({tag, ".ready"},     t, 32'(o_rdy), 32'd1);
      chk({tag, ".busy"},      t, 32'(o_bsy), 32'd0);
      chk({tag, ".row0"},      t, o_r0, 32'd0);
      chk({tag, ".row1"},      t, o_r1, 32'd0);
      chk({tag, ".col0"},      t, o_c0, 32'd0);
      chk({tag, ".col1"},      t, o_c1, 32'd0);
   endtask

   task automatic check_cycle(input string tag, input int t, input int g, input int d);
      int          p;
      int          w;
      logic        ld, fd, rdy;
      logic [31:0] e [4];
      p   = g + 1;
      ld  = 1'b0;
      fd  = 1'b0;
      rdy = 1'b1;
      for (int i = 0; i < 4; i++) e[i] = 32'd0;
      if (t >= 1 && t <= 4 * p) begin
         w   = (t - 1) / p;
         ld  = ((t - 1) % p) == 0;
         rdy = 1'b0;
         for (int i = 0; i < 4; i++) e[i] = ew[w][i];
      end else if (t >= 1 && t <= 4 * p + d + 1) begin
         rdy = 1'b0;
         fd  = (t == 4 * p + d + 1);
      end
      chk({tag, ".load_in"},   t, 32'(o_ld),  32'(ld));
      chk({tag, ".feed_done"}, t, 32'(o_fd),  32'(fd));
      chk({tag, ".ready"},     t, 32'(o_rdy), 32'(rdy));
      chk({tag, ".busy"},      t, 32'(o_bsy), 32'(!rdy));
      chk({tag, ".row0"},      t, o_r0, e[0]);
      chk({tag, ".row1"},      t, o_r1, e[1]);
      chk({tag, ".col0"},      t, o_c0, e[2]);
      chk({tag, ".col1"},      t, o_c1, e[3]);
   endtask

   // mode 0: plain run; 1: start re-pulsed with new operands in GAP and in DONE;
   // 2: asynchronous reset in mid-cycle at t == abort_t.
   task automatic run_seq(input string tag, input bit fast, input int g, input int d,
                          input int mode, input int abort_t);
      int tdone;
      tdone    = 4 * (g + 1) + d + 1;
      sel_fast = fast;
      @(negedge clk);
      if (fast) start_f = 1'b1; else start_s = 1'b1;
      @(negedge clk);
      start_f = 1'b0;
      start_s = 1'b0;
      for (int t = 1; t <= tdone + 3; t++) begin
         check_cycle(tag, t, g, d);
         if (mode == 2 && t == abort_t) begin
            #2 rst_n = 1'b0;
            #1 check_idle_out({tag, ".abort"}, t);
            return;
         end
         if (mode == 1) begin
            if (t == 5) begin
               start_s = 1'b1;
               a11 = 32'hDEAD_0001; a12 = 32'hDEAD_0002;
               b21 = 32'hDEAD_0003; b22 = 32'hDEAD_0004;
            end
            if (t == 6) start_s = 1'b0;
            if (t == tdone) start_s = 1'b1;
            if (t == tdone + 1) start_s = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      n_chk    = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      start_s  = 1'b0;
      start_f  = 1'b0;
      sel_fast = 1'b0;
      set_ops(32'd1, 32'd2, 32'd3, 32'd4, 32'd1, 32'd2, 32'd3, 32'd4);

      // Reset state on both instances.
      @(negedge clk);
      check_idle_out("rst_slow", 0);
      sel_fast = 1'b1;
      #1 check_idle_out("rst_fast", 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: A = B = [[1,2],[3,4]], default timing.
      run_seq("s1", 1'b0, 15, 100, 0, 0);

      // 2: A = [[4,2],[1,8]], B = [[8,2],[1,4]].
      set_ops(32'd4, 32'd2, 32'd1, 32'd8, 32'd8, 32'd2, 32'd1, 32'd4);
      run_seq("s2", 1'b0, 15, 100, 0, 0);

      // 3: short timing instance.
      set_ops(32'd1, 32'd2, 32'd3, 32'd4, 32'd1, 32'd2, 32'd3, 32'd4);
      run_seq("s3", 1'b1, 1, 1, 0, 0);

      // 4: start re-pulsed during GAP and DONE, operands changed after acceptance.
      set_ops(32'd1, 32'd2, 32'd3, 32'd4, 32'd1, 32'd2, 32'd3, 32'd4);
      run_seq("s4", 1'b0, 15, 100, 1, 0);

      // 5: reset during the wave 2 gap, then no stray feed_done, then a clean run.
      set_ops(32'd1, 32'd2, 32'd3, 32'd4, 32'd1, 32'd2, 32'd3, 32'd4);
      run_seq("s5", 1'b0, 15, 100, 2, 37);
      @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         chk("s5.post.feed_done", t, 32'(o_fd), 32'd0);
         chk("s5.post.ready", t, 32'(o_rdy), 32'd1);
         chk("s5.post.load_in", t, 32'(o_ld), 32'd0);
      end
      set_ops(32'd4, 32'd2, 32'd1, 32'd8, 32'd8, 32'd2, 32'd1, 32'd4);
      run_seq("s5.rerun", 1'b0, 15, 100, 0, 0);

      // 6: all-ones operands on both instances.
      set_ops('1, '1, '1, '1, '1, '1, '1, '1);
      run_seq("s6", 1'b0, 15, 100, 0, 0);
      run_seq("s6f", 1'b1, 1, 1, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
